// File: rtl/formula_sqrt_sum_pipe_fsm.sv
// Sum of integer square roots over N_ARGS terms, issued to an external pipelined isqrt unit.
// Optional watchdog with err output when FORMULA_SQRT_SUM_TIMEOUT_EN is defined.
module formula_sqrt_sum_pipe_fsm #(
    parameter  int N_ARGS        = 3,
    parameter  int ARG_W         = 32,
    parameter  int ISQRT_LATENCY = 4,
    localparam int RES_W         = ARG_W/2 + $clog2(N_ARGS) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arg_vld,
    output logic                    arg_rdy,
    input  logic [N_ARGS*ARG_W-1:0] args,
    output logic                    res_vld,
    input  logic                    res_rdy,
    output logic [RES_W-1:0]        res,
    output logic                    isqrt_x_vld,
    output logic [ARG_W-1:0]        isqrt_x,
    input  logic                    isqrt_y_vld,
    input  logic [ARG_W/2-1:0]      isqrt_y
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
    ,
    output logic                    err
`endif
);

    localparam int CNT_W = $clog2(N_ARGS + 1);
    localparam int FL_W  = $clog2(ISQRT_LATENCY + 2);

    typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [FL_W-1:0]         flush_cnt;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        res_cnt;
    logic [RES_W-1:0]        acc;
    logic [N_ARGS*ARG_W-1:0] args_q;
    logic [ARG_W-1:0]        issue_term;
    logic                    accept;
    logic                    collect;
    logic                    last_res;
    logic [RES_W-1:0]        acc_next;

    assign arg_rdy  = (state == IDLE);
    assign accept   = arg_vld && arg_rdy;
    assign collect  = isqrt_y_vld && (state == ISSUE || state == DRAIN);
    assign acc_next = acc + RES_W'(isqrt_y);
    assign last_res = collect && (res_cnt == CNT_W'(N_ARGS - 1));

    // Term 0 goes straight from the input port so issue starts in the accept cycle.
    assign isqrt_x_vld = accept || (state == ISSUE);
    assign isqrt_x     = accept ? args[ARG_W-1:0] :
                         (state == ISSUE) ? issue_term : '0;

    always_comb begin
        issue_term = '0;
        for (int i = 0; i < N_ARGS; i++) begin
            if (issue_cnt == CNT_W'(i)) issue_term = args_q[i*ARG_W +: ARG_W];
        end
    end

`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
    localparam int WD_LIMIT = N_ARGS + ISQRT_LATENCY + 4;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire = (state == ISSUE || state == DRAIN) &&
                       (wd_cnt == WD_W'(WD_LIMIT - 1)) && !last_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            flush_cnt <= FL_W'(ISQRT_LATENCY);
            issue_cnt <= '0;
            res_cnt   <= '0;
            acc       <= '0;
            args_q    <= '0;
            res_vld   <= 1'b0;
            res       <= '0;
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
            wd_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                // Results still in the isqrt pipe from before reset drain out here unseen.
                FLUSH: begin
                    if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt <= FL_W'(1)) state <= IDLE;
                end
                IDLE: begin
                    if (accept) begin
                        args_q    <= args;
                        acc       <= '0;
                        res_cnt   <= '0;
                        issue_cnt <= CNT_W'(1);
                        state     <= (N_ARGS > 1) ? ISSUE : DRAIN;
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
                        wd_cnt    <= WD_W'(1);
`endif
                    end
                end
                ISSUE, DRAIN: begin
                    if (state == ISSUE) begin
                        if (issue_cnt == CNT_W'(N_ARGS - 1)) state <= DRAIN;
                        else issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (collect) begin
                        acc     <= acc_next;
                        res_cnt <= res_cnt + 1'b1;
                    end
                    if (last_res) begin
                        res     <= acc_next;
                        res_vld <= 1'b1;
                        state   <= DONE;
                    end
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
                    if (wd_expire) begin
                        err       <= 1'b1;
                        state     <= FLUSH;
                        flush_cnt <= FL_W'(ISQRT_LATENCY);
                    end
`endif
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_formula_sqrt_sum_pipe_fsm.sv
// Scoreboard bench for formula_sqrt_sum_pipe_fsm with a latency-4 isqrt model.
// Timeout scenario runs only when FORMULA_SQRT_SUM_TIMEOUT_EN is defined.
module tb_formula_sqrt_sum_pipe_fsm;

    localparam int N_ARGS = 3;
    localparam int ARG_W  = 32;
    localparam int LAT    = 4;
    localparam int RES_W  = ARG_W/2 + $clog2(N_ARGS) + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    arg_vld = 1'b0;
    logic                    arg_rdy;
    logic [N_ARGS*ARG_W-1:0] args = '0;
    logic                    res_vld;
    logic                    res_rdy = 1'b1;
    logic [RES_W-1:0]        res;
    logic                    isqrt_x_vld;
    logic [ARG_W-1:0]        isqrt_x;
    logic                    isqrt_y_vld;
    logic [ARG_W/2-1:0]      isqrt_y;
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
    logic                    err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [RES_W-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    formula_sqrt_sum_pipe_fsm #(
        .N_ARGS(N_ARGS), .ARG_W(ARG_W), .ISQRT_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld), .arg_rdy(arg_rdy), .args(args),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
        .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
        .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y)
`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
        , .err(err)
`endif
    );

    function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (64'(t) * 64'(t) <= 64'(v)) r = t;
        end
        return r[15:0];
    endfunction

    // Pipelined isqrt stand-in; can drop one issue and inject stray results.
    logic [LAT-1:0] pipe_vld = '0;
    logic [15:0]    pipe_y [LAT];
    int             issue_count = 0;
    int             drop_at = -1;
    logic           stray_vld = 1'b0;
    logic [15:0]    stray_y = '0;

    always @(posedge clk) begin
        pipe_vld  <= {pipe_vld[LAT-2:0], isqrt_x_vld && (issue_count != drop_at)};
        pipe_y[0] <= ref_isqrt(isqrt_x);
        for (int i = 1; i < LAT; i++) pipe_y[i] <= pipe_y[i-1];
        if (isqrt_x_vld) issue_count <= issue_count + 1;
    end

    assign isqrt_y_vld = pipe_vld[LAT-1] | stray_vld;
    assign isqrt_y     = stray_vld ? stray_y : pipe_y[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Result handshakes are scored against the queue of expected sums.
    always @(negedge clk) begin
        if (!rst && res_vld && res_rdy) begin
            if (exp_q.size() == 0) checkOutput("res_unexpected", 32'd1, 32'd0);
            else checkOutput("res", 32'(res), 32'(exp_q.pop_front()));
        end
    end

`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
    int err_cyc = -1;
    int err_pulses = 0;
    always @(negedge clk) begin
        if (!rst && err) begin
            err_pulses++;
            err_cyc = cyc;
        end
    end
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        arg_vld = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic checkFlush(input string tag);
        for (int i = 0; i < LAT; i++) begin
            checkOutput({tag, "_rdy_low"}, 32'(arg_rdy), 32'd0);
            step();
        end
        checkOutput({tag, "_rdy_high"}, 32'(arg_rdy), 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input bit expect_res,
                                 output int acc_cyc);
        int g;
        logic [RES_W-1:0] e;
        g = 0;
        while (!arg_rdy && g < 100) begin
            step();
            g++;
        end
        checkOutput("arg_rdy_wait", 32'(arg_rdy), 32'd1);
        args = {a2, a1, a0};
        arg_vld = 1'b1;
        #1;
        checkOutput("x0_vld", 32'(isqrt_x_vld), 32'd1);
        checkOutput("x0", isqrt_x, a0);
        if (expect_res) begin
            e = RES_W'(ref_isqrt(a0)) + RES_W'(ref_isqrt(a1)) + RES_W'(ref_isqrt(a2));
            exp_q.push_back(e);
        end
        acc_cyc = cyc;
        step();
        arg_vld = 1'b0;
        args = {3{32'hDEAD_BEEF}};
    endtask

    task automatic waitResult(output int rc);
        int g;
        g = 0;
        while (!res_vld && g < 60) begin
            step();
            g++;
        end
        checkOutput("res_vld_seen", 32'(res_vld), 32'd1);
        rc = cyc;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int c0, c1, c2, c3, c4, c5, rc;
        logic [RES_W-1:0] held;
        bit stable, leak;

        doReset();
        checkOutput("rst_arg_rdy", 32'(arg_rdy), 32'd0);
        checkOutput("rst_res_vld", 32'(res_vld), 32'd0);
        checkOutput("rst_x_vld", 32'(isqrt_x_vld), 32'd0);
        checkOutput("rst_res", 32'(res), 32'd0);
        checkFlush("reset");

        // Basic set: terms 4, 9, 16 issued back to back.
        applyStimulus(32'd4, 32'd9, 32'd16, 1'b1, c0);
        checkOutput("x1_vld", 32'(isqrt_x_vld), 32'd1);
        checkOutput("x1", isqrt_x, 32'd9);
        step();
        checkOutput("x2_vld", 32'(isqrt_x_vld), 32'd1);
        checkOutput("x2", isqrt_x, 32'd16);
        step();
        checkOutput("x_idle_vld", 32'(isqrt_x_vld), 32'd0);
        checkOutput("x_idle_zero", isqrt_x, 32'd0);
        waitResult(rc);
        checkOutput("latency", 32'(rc - c0), 32'd7);
        checkOutput("basic_res_const", 32'(res), 32'd9);

        // Back-to-back accept spacing with res_rdy high.
        applyStimulus(32'd100, 32'd2500, 32'd1, 1'b1, c1);
        checkOutput("accept_interval", 32'(c1 - c0), 32'd8);
        waitResult(rc);
        step();

        // Extreme operands under result backpressure.
        res_rdy = 1'b0;
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c2);
        waitResult(rc);
        held = res;
        stable = 1'b1;
        leak = 1'b0;
        arg_vld = 1'b1;
        args = {32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 10; i++) begin
            step();
            if (!res_vld || res !== held) stable = 1'b0;
            if (arg_rdy || isqrt_x_vld) leak = 1'b1;
        end
        checkOutput("bp_stable", 32'(stable), 32'd1);
        checkOutput("bp_no_accept", 32'(leak), 32'd0);
        checkOutput("extreme_res_const", 32'(held), 32'd196605);
        res_rdy = 1'b1;
        step();
        arg_vld = 1'b0;
        checkOutput("bp_post_rdy", 32'(arg_rdy), 32'd1);
        checkOutput("bp_post_vld", 32'(res_vld), 32'd0);

        // Stray isqrt result in IDLE must not reach the accumulator.
        stray_y = 16'd100;
        stray_vld = 1'b1;
        step();
        stray_vld = 1'b0;
        applyStimulus(32'd1, 32'd1, 32'd1, 1'b1, c3);
        waitResult(rc);
        step();

        // Reset while draining: no result, full flush, then a clean set.
        applyStimulus(32'd4, 32'd9, 32'd16, 1'b0, c4);
        step();
        step();
        checkOutput("drain_x_vld", 32'(isqrt_x_vld), 32'd0);
        checkOutput("drain_res_vld", 32'(res_vld), 32'd0);
        step();
        doReset();
        checkOutput("drain_rst_res_vld", 32'(res_vld), 32'd0);
        checkFlush("drain_rst");
        applyStimulus(32'd0, 32'd0, 32'd25, 1'b1, c5);
        waitResult(rc);
        step();

`ifdef FORMULA_SQRT_SUM_TIMEOUT_EN
        begin
            int c6, c7, g;
            drop_at = issue_count + 1;
            applyStimulus(32'd9, 32'd16, 32'd25, 1'b0, c6);
            g = 0;
            while (err_cyc < 0 && g < 40) begin
                step();
                g++;
            end
            checkOutput("err_cycle", 32'(err_cyc - c6), 32'd11);
            checkOutput("err_width", 32'(err), 32'd0);
            checkOutput("err_pulses", 32'(err_pulses), 32'd1);
            checkOutput("err_no_res", 32'(res_vld), 32'd0);
            for (int i = 0; i < LAT - 1; i++) begin
                checkOutput("to_flush_rdy_low", 32'(arg_rdy), 32'd0);
                step();
            end
            checkOutput("to_flush_rdy_high", 32'(arg_rdy), 32'd1);
            drop_at = -1;
            applyStimulus(32'd9, 32'd16, 32'd25, 1'b1, c7);
            waitResult(rc);
            step();
        end
`endif

        step();
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
